// File: rtl/seq_bw_mult.sv
// seq_bw_mult: multi-cycle Baugh-Wooley array multiplier.
// Adds ROWS partial-product rows per clock into a 2*WIDTH accumulator and
// publishes the finished product in p with a one-cycle done pulse.
module seq_bw_mult #(
  parameter int WIDTH = 6,
  parameter int ROWS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int NCYC = WIDTH / ROWS;
  localparam int PW   = 2 * WIDTH;
  // Wide enough to hold any row index 0..WIDTH-1 and the row counter.
  localparam int CW   = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);
  localparam logic [CW-1:0] ROWS_C   = CW'(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);
  // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1).
  localparam logic [PW-1:0] CORR     = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              last_s;

  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              sgn_r;
  logic [PW-1:0]     acc_r;
  logic [PW-1:0]     p_r;
  logic              busy_r;
  logic              done_r;

  logic [CW-1:0]     base_s;
  logic [CW-1:0]     idx_s;
  logic [WIDTH-1:0]  row_s;
  logic [PW-1:0]     sum_s;

  // Select bit idx of v without a variable-width part select.
  function automatic logic pick_bit(input logic [WIDTH-1:0] v, input logic [CW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      r = r | (v[i] & (idx == CW'(i)));
    end
    return r;
  endfunction

  // One partial-product row, with the Baugh-Wooley inversions in signed mode.
  function automatic logic [WIDTH-1:0] bw_row(input logic abit, input logic [WIDTH-1:0] bv,
                                              input logic signed_mode, input logic last_row);
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] r;
    pp = bv & {WIDTH{abit}};
    if (!signed_mode) begin
      r = pp;
    end else if (last_row) begin
      r = {pp[WIDTH-1], ~pp[WIDTH-2:0]};
    end else begin
      r = {~pp[WIDTH-1], pp[WIDTH-2:0]};
    end
    return r;
  endfunction

  // Next-state logic and start acceptance (accepted only in IDLE and DONE).
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_CALC;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = S_DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt_s = S_CALC;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Accumulator plus the ROWS partial-product rows selected by the row counter.
  always_comb begin
    base_s = cnt_r * ROWS_C;
    idx_s  = {CW{1'b0}};
    row_s  = {WIDTH{1'b0}};
    sum_s  = acc_r;
    for (int j = 0; j < ROWS; j++) begin
      idx_s = base_s + CW'(j);
      row_s = bw_row(pick_bit(a_r, idx_s), b_r, sgn_r, idx_s == LAST_ROW);
      sum_s = sum_s + ({{WIDTH{1'b0}}, row_s} << idx_s);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == S_CALC);
      done_r <= (state_nxt_s == S_DONE);
    end
  end

  // Operand capture, row accumulation and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sgn_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
      acc_r <= {PW{1'b0}};
      p_r   <= {PW{1'b0}};
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      sgn_r <= sgn;
      cnt_r <= {CW{1'b0}};
      acc_r <= sgn ? CORR : {PW{1'b0}};
    end else if (state_r == S_CALC) begin
      acc_r <= sum_s;
      if (last_s) begin
        p_r   <= sum_s;
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign p    = p_r;

endmodule

// File: tb/tb_seq_bw_mult.sv
// Self-checking bench for seq_bw_mult: directed vectors on a 6x6/ROWS=2
// instance, then exhaustive sweeps on four parameter sets in parallel.
module tb_seq_bw_mult;

  logic        clk;
  logic        rst_n;
  logic        st [4];
  logic        sg [4];
  logic [5:0]  ai [4];
  logic [5:0]  bi [4];
  logic        bz [4];
  logic        dn [4];
  logic [11:0] pp [3];
  logic [7:0]  p4;

  int n_tests = 0;
  int n_fail  = 0;

  seq_bw_mult #(.WIDTH(6), .ROWS(2)) u_m62 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sgn(sg[0]), .a(ai[0]), .b(bi[0]),
    .busy(bz[0]), .done(dn[0]), .p(pp[0]));
  seq_bw_mult #(.WIDTH(6), .ROWS(1)) u_m61 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sgn(sg[1]), .a(ai[1]), .b(bi[1]),
    .busy(bz[1]), .done(dn[1]), .p(pp[1]));
  seq_bw_mult #(.WIDTH(6), .ROWS(6)) u_m66 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sgn(sg[2]), .a(ai[2]), .b(bi[2]),
    .busy(bz[2]), .done(dn[2]), .p(pp[2]));
  seq_bw_mult #(.WIDTH(4), .ROWS(2)) u_m42 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .sgn(sg[3]), .a(ai[3][3:0]), .b(bi[3][3:0]),
    .busy(bz[3]), .done(dn[3]), .p(p4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op on the 6x6/ROWS=2 instance from IDLE: latency, busy length,
  // p held during CALC, result, and done dropping after one cycle.
  task automatic run_op(input string tag, input logic s, input logic [5:0] x,
                        input logic [5:0] y, input logic [11:0] exp_p);
    logic [11:0] prev;
    logic        held;
    int          lat;
    int          bcnt;
    prev  = pp[0];
    held  = 1'b1;
    sg[0] = s;
    ai[0] = x;
    bi[0] = y;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!dn[0] && lat < 20) begin
      if (bz[0]) bcnt++;
      if (pp[0] !== prev) held = 1'b0;
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " busy_cycles"}, 32'(bcnt), 32'd3);
    check({tag, " p_held"}, {31'd0, held}, 32'd1);
    check({tag, " p"}, {20'd0, pp[0]}, {20'd0, exp_p});
    tick();
    check({tag, " done_pulse"}, {31'd0, dn[0]}, 32'd0);
    check({tag, " busy_idle"}, {31'd0, bz[0]}, 32'd0);
  endtask

  // Exhaustive sweep of both modes on instance k, back-to-back ops.
  task automatic sweep(input int k, input int w, input int ncyc);
    int          lat;
    int          sx;
    int          sy;
    int          prod;
    logic [31:0] obs;
    for (int mode = 0; mode < 2; mode++) begin
      for (int x = 0; x < (1 << w); x++) begin
        for (int y = 0; y < (1 << w); y++) begin
          sg[k] = mode[0];
          ai[k] = 6'(x);
          bi[k] = 6'(y);
          st[k] = 1'b1;
          tick();
          st[k] = 1'b0;
          lat = 0;
          while (!dn[k] && lat < 40) begin
            tick();
            lat++;
          end
          sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
          sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
          prod = (mode == 1) ? sx * sy : x * y;
          prod = prod & ((1 << (2 * w)) - 1);
          if (k == 3) obs = {24'd0, p4};
          else        obs = {20'd0, pp[k]};
          check($sformatf("sweep%0d latency m%0d a%0h b%0h", k, mode, x, y), 32'(lat), 32'(ncyc));
          check($sformatf("sweep%0d p m%0d a%0h b%0h", k, mode, x, y), obs, 32'(prod));
        end
      end
    end
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      sg[i] = 1'b0;
      ai[i] = 6'd0;
      bi[i] = 6'd0;
    end
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, bz[0]}, 32'd0);
    check("reset done", {31'd0, dn[0]}, 32'd0);
    check("reset p", {20'd0, pp[0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("s_m32_m32", 1'b1, 6'h20, 6'h20, 12'h400);
    run_op("s_m32_31",  1'b1, 6'h20, 6'h1F, 12'hC20);
    run_op("s_7_m3",    1'b1, 6'h07, 6'h3D, 12'hFEB);
    run_op("s_0_m1",    1'b1, 6'h00, 6'h3F, 12'h000);
    run_op("u_63_63",   1'b0, 6'h3F, 6'h3F, 12'hF81);
    run_op("s_m1_m1",   1'b1, 6'h3F, 6'h3F, 12'h001);

    // start held high; inputs switched mid-CALC must not disturb the op.
    sg[0] = 1'b1; ai[0] = 6'h07; bi[0] = 6'h3D; st[0] = 1'b1;
    tick();
    check("b2b busy_e0", {31'd0, bz[0]}, 32'd1);
    ai[0] = 6'h01; bi[0] = 6'h01;
    tick();
    tick();
    sg[0] = 1'b0; ai[0] = 6'h3F; bi[0] = 6'h3F;
    tick();
    check("b2b done1", {31'd0, dn[0]}, 32'd1);
    check("b2b p1", {20'd0, pp[0]}, 32'h0000_0FEB);
    tick();
    check("b2b done1_drop", {31'd0, dn[0]}, 32'd0);
    check("b2b busy2", {31'd0, bz[0]}, 32'd1);
    check("b2b p1_hold", {20'd0, pp[0]}, 32'h0000_0FEB);
    tick();
    tick();
    sg[0] = 1'b1; ai[0] = 6'h01; bi[0] = 6'h01;
    tick();
    check("b2b done2", {31'd0, dn[0]}, 32'd1);
    check("b2b p2", {20'd0, pp[0]}, 32'h0000_0F81);
    tick();
    check("b2b done2_drop", {31'd0, dn[0]}, 32'd0);
    check("b2b busy3", {31'd0, bz[0]}, 32'd1);
    st[0] = 1'b0;
    tick();
    tick();
    tick();
    check("b2b done3", {31'd0, dn[0]}, 32'd1);
    check("b2b p3", {20'd0, pp[0]}, 32'h0000_0001);
    tick();
    check("b2b done3_drop", {31'd0, dn[0]}, 32'd0);
    check("b2b idle", {31'd0, bz[0]}, 32'd0);

    // Reset during CALC with cnt=1 aborts the op.
    sg[0] = 1'b1; ai[0] = 6'h20; bi[0] = 6'h20; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", {31'd0, bz[0]}, 32'd0);
    check("rst_mid done", {31'd0, dn[0]}, 32'd0);
    check("rst_mid p", {20'd0, pp[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dn[0]) seen_done = 1'b1;
    end
    check("rst_mid no_done", {31'd0, seen_done}, 32'd0);
    run_op("post_rst", 1'b1, 6'h07, 6'h3D, 12'hFEB);

    fork
      sweep(0, 6, 3);
      sweep(1, 6, 6);
      sweep(2, 6, 1);
      sweep(3, 4, 2);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
